// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO block family: register addresses and default width.
package gpio_pkg;

  localparam int GPIO_WIDTH = 32;

  localparam logic [1:0] GPIO_ADDR_LEVEL   = 2'd0;
  localparam logic [1:0] GPIO_ADDR_RISE_EN = 2'd1;
  localparam logic [1:0] GPIO_ADDR_FALL_EN = 2'd2;
  localparam logic [1:0] GPIO_ADDR_PENDING = 2'd3;

endpackage

// File: rtl/gpio_edge_capture_if.sv
// Register bus shared by the GPIO blocks: select, strobes, address and data.
interface gpio_edge_capture_if #(
  parameter int WIDTH = 32
);

  logic             sel;
  logic             wen;
  logic             ren;
  logic [1:0]       addr;
  logic [WIDTH-1:0] datain;
  logic [WIDTH-1:0] dataout;

  modport master (
    output sel, wen, ren, addr, datain,
    input  dataout
  );

  modport slave (
    input  sel, wen, ren, addr, datain,
    output dataout
  );

endinterface

// File: rtl/gpio_sync.sv
// WIDTH x SYNC_STAGES flop chain bringing asynchronous pad inputs into the clk domain.
module gpio_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  // NOTE: every flop here, including the array, resets; a synchroniser must come out of reset at a known value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_edge_capture.sv
// GPIO input front end: synchronise pads, detect enabled edges, latch them as pending, raise irq.
module gpio_edge_capture
  import gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] pins,
  gpio_edge_capture_if.slave bus,
  output logic [WIDTH-1:0] level,
  output logic             irq
);

  localparam int                ARM_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0]  ARM_MAX = ARM_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] pending;
  logic [ARM_W-1:0] arm_cnt;

  logic             armed;
  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] set_mask;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] rdata;

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .din  (pins),
    .dout (level)
  );

  assign wr    = bus.sel & bus.wen;
  assign rd    = bus.sel & bus.ren;
  assign armed = (arm_cnt == ARM_MAX);

  // Masking until the chain and prev have refilled hides the 0->1 step of a pin held high through reset.
  assign rise     = level & ~prev;
  assign fall     = ~level & prev;
  assign set_mask = armed ? ((rise & rise_en) | (fall & fall_en)) : '0;
  assign clr_mask = (wr && bus.addr == GPIO_ADDR_PENDING) ? bus.datain : '0;

  // NOTE: a default before the case keeps this purely combinational; a missed arm would infer a latch.
  always_comb begin
    rdata = '0;
    case (bus.addr)
      GPIO_ADDR_LEVEL:   rdata = level;
      GPIO_ADDR_RISE_EN: rdata = rise_en;
      GPIO_ADDR_FALL_EN: rdata = fall_en;
      GPIO_ADDR_PENDING: rdata = pending;
      default:           rdata = '0;
    endcase
  end

  // NOTE: non-blocking assignments let the read mux see pre-write values when read and write share a cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev        <= '0;
      rise_en     <= '0;
      fall_en     <= '0;
      pending     <= '0;
      arm_cnt     <= '0;
      irq         <= 1'b0;
      bus.dataout <= '0;
    end else begin
      prev <= level;
      if (!armed) arm_cnt <= arm_cnt + 1'b1;

      if (wr && bus.addr == GPIO_ADDR_RISE_EN) rise_en <= bus.datain;
      if (wr && bus.addr == GPIO_ADDR_FALL_EN) fall_en <= bus.datain;

      // A new edge outranks a simultaneous write-1-to-clear.
      pending <= (pending & ~clr_mask) | set_mask;
      irq     <= |pending;

      if (rd) bus.dataout <= rdata;
    end
  end

endmodule

// File: tb/tb_gpio_edge_capture.sv
// Directed bench for gpio_edge_capture with SYNC_STAGES=2 and hand-computed expectations.
`timescale 1ns/1ps
module tb_gpio_edge_capture;

  logic        clk;
  logic        rstn;
  logic [31:0] pins;
  logic [31:0] level;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  gpio_edge_capture_if #(.WIDTH(32)) bus ();

  gpio_edge_capture #(
    .WIDTH       (32),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .pins  (pins),
    .bus   (bus.slave),
    .level (level),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one posedge and step 1ns past it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.sel = 1'b1; bus.wen = 1'b1; bus.addr = a; bus.datain = d;
    tick();
    bus.sel = 1'b0; bus.wen = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input string tag, input logic [31:0] exp);
    bus.sel = 1'b1; bus.ren = 1'b1; bus.addr = a;
    tick();
    bus.sel = 1'b0; bus.ren = 1'b0;
    check(tag, bus.dataout, exp);
  endtask

  initial begin
    rstn = 1'b0; pins = 32'hFFFF_FFFF;
    bus.sel = 1'b0; bus.wen = 1'b0; bus.ren = 1'b0; bus.addr = 2'd0; bus.datain = '0;
    tick(3);
    check("rst_dataout", bus.dataout, 32'h0);
    check("rst_level", level, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);

    // Pins held high through reset must not look like a rising edge.
    rstn = 1'b1;
    bus_write(2'd1, 32'hFFFF_FFFF);
    tick(6);
    check("held_high_level", level, 32'hFFFF_FFFF);
    check("held_high_irq", {31'b0, irq}, 32'h0);
    bus_read(2'd3, "held_high_pending", 32'h0);
    bus_read(2'd1, "rise_en_readback", 32'hFFFF_FFFF);

    // Rise on bit 0: pending at E3, irq at E4.
    bus_write(2'd1, 32'h0000_0001);
    pins = 32'h0;
    tick(4);
    bus_read(2'd3, "bit0_pre_pending", 32'h0);
    pins = 32'h0000_0001;
    tick(2);
    check("bit0_irq_e2", {31'b0, irq}, 32'h0);
    bus.sel = 1'b1; bus.ren = 1'b1; bus.addr = 2'd3;
    tick();
    check("bit0_pending_before_e3", bus.dataout, 32'h0);
    check("bit0_irq_e3", {31'b0, irq}, 32'h0);
    tick();
    check("bit0_pending_after_e3", bus.dataout, 32'h1);
    check("bit0_irq_e4", {31'b0, irq}, 32'h1);
    bus.sel = 1'b0; bus.ren = 1'b0;
    bus_read(2'd0, "bit0_level_read", 32'h1);

    // Clear bit 0; irq drops one cycle after the clearing write.
    bus_write(2'd3, 32'h0000_0001);
    check("bit0_irq_after_w1c", {31'b0, irq}, 32'h1);
    tick();
    check("bit0_irq_cleared", {31'b0, irq}, 32'h0);

    // Falling edge on bit 31.
    bus_write(2'd2, 32'h8000_0000);
    pins = 32'h8000_0001;
    tick(4);
    check("bit31_rise_ignored_irq", {31'b0, irq}, 32'h0);
    pins = 32'h0000_0001;
    tick(4);
    bus_read(2'd3, "bit31_pending", 32'h8000_0000);
    check("bit31_irq", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h8000_0000);
    check("bit31_irq_hold", {31'b0, irq}, 32'h1);
    tick();
    check("bit31_irq_cleared", {31'b0, irq}, 32'h0);
    bus_read(2'd3, "bit31_pending_cleared", 32'h0);

    // Edge on bit 4 in the same cycle as a W1C of bit 4: set wins.
    bus_write(2'd1, 32'h0000_0011);
    pins = 32'h0000_0011;
    tick(2);
    bus_write(2'd3, 32'h0000_0010);
    bus_read(2'd3, "bit4_set_wins", 32'h0000_0010);
    bus_write(2'd3, 32'h0000_0010);
    bus_read(2'd3, "bit4_w1c", 32'h0);

    // Simultaneous read and write returns the pre-write value.
    bus_write(2'd1, 32'h0);
    bus.sel = 1'b1; bus.wen = 1'b1; bus.ren = 1'b1; bus.addr = 2'd1; bus.datain = 32'hA5A5_A5A5;
    tick();
    bus.sel = 1'b0; bus.wen = 1'b0; bus.ren = 1'b0;
    check("rw_same_cycle", bus.dataout, 32'h0);
    bus_read(2'd1, "rw_followup", 32'hA5A5_A5A5);
    bus_write(2'd0, 32'h0);
    bus_read(2'd0, "level_write_ignored", 32'h0000_0011);
    bus.wen = 1'b1; bus.ren = 1'b1; bus.addr = 2'd2; bus.datain = 32'h1234_5678;
    tick();
    bus.wen = 1'b0; bus.ren = 1'b0;
    check("unselected_read_holds", bus.dataout, 32'h0000_0011);
    bus_read(2'd2, "unselected_write_ignored", 32'h8000_0000);

    // Build PENDING=0xF, then reset mid-operation.
    bus_write(2'd1, 32'h0000_000F);
    pins = 32'h0000_0010;
    tick(4);
    pins = 32'h0000_001F;
    tick(4);
    bus_read(2'd3, "pre_reset_pending", 32'h0000_000F);
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    #3;
    rstn = 1'b0;
    #1;
    check("midrst_dataout", bus.dataout, 32'h0);
    check("midrst_level", level, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    pins = 32'h0;
    tick(2);

    // An edge that would set pending at E3 after release is masked.
    rstn = 1'b1;
    pins = 32'h0000_0020;
    bus_write(2'd1, 32'h0000_0020);
    tick(5);
    bus_read(2'd3, "rearm_masked", 32'h0);
    check("rearm_irq", {31'b0, irq}, 32'h0);
    pins = 32'h0;
    tick(4);
    pins = 32'h0000_0020;
    tick(4);
    bus_read(2'd3, "rearmed_pending", 32'h0000_0020);
    check("rearmed_irq", {31'b0, irq}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
